seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Parametrised, memory-mapped seven-segment scan controller on the CPU IO bus.
//  Selected by DigitalCtrl (seg_cs) from the MemOrIO address decode; CPU sw/lw reach
//  three registers: hex DATA, CTRL (enable/blank), DP mask.
//  Time-multiplexes NUM_DIGITS digits with a hex decoder and per-digit blanking.
//  Replaces driving digital_tube[31:0]/digital[7:0] straight from write_data.
// PARAMETERS
//  NUM_DIGITS   8      digits scanned; legal 1..8; DATA holds 4*NUM_DIGITS nibbles
//  SCAN_DIV     50000  clk cycles per digit slot; legal >=1
// PORTS
//  clk        in   1           cpu_clk; all state on rising edge
//  rst        in   1           async, active-low reset
//  seg_cs     in   1           register select (DigitalCtrl)
//  seg_we     in   1           1=write, 0=read; qualified by seg_cs
//  seg_addr   in   2           0=DATA 1=CTRL 2=DP 3=reserved
//  seg_wdata  in   32          write data (write_data from MemOrIO)
//  seg_rdata  out  32          read data, 1-cycle latency
//  seg_an     out  NUM_DIGITS  digit enables, active-high, one-hot or all-zero
//  seg_out    out  8           {dp,g,f,e,d,c,b,a}, active-high
// BEHAVIOUR
//  Reset (rst=0, async): DATA=0, CTRL=0x1 (enabled, none blanked), DP=0, div_cnt=0,
//   idx=0, seg_an=0, seg_out=0, seg_rdata=0.
//  Write: seg_cs&seg_we at edge -> addressed reg updated; bits above 4*NUM_DIGITS
//   (DATA), NUM_DIGITS (DP), NUM_DIGITS+8 (CTRL) stored as 0. addr 3 ignored.
//  CTRL: bit0=EN; bits[8+:NUM_DIGITS]=blank mask (1=digit dark); bits[7:4]=duty (opt).
//  Read: seg_cs&!seg_we at edge N -> seg_rdata = reg value before any edge-N write,
//   visible after edge N; held until next read; addr 3 reads 0.
//  Scan: div_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and idx advances,
//   idx NUM_DIGITS-1 -> 0. SCAN_DIV=1: idx advances every cycle.
//  Outputs registered: at each edge seg_an/seg_out computed from current idx and regs
//   -> 1-cycle latency from idx or register change to pins.
//   seg_an = 1<<idx; seg_out[6:0] = hex(DATA[4*idx+:4]); seg_out[7] = DP[idx].
//   hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  Blanked digit (mask bit 1): seg_an bit 0 and seg_out=0 for that slot; scan continues.
//  EN=0: div_cnt and idx held at 0, seg_an=0, seg_out=0 from next edge; EN 0->1 restarts
//   at digit 0 with a full slot.
//  Write during a slot: new value shown from next edge (no waiting for slot boundary).
//  Reset mid-slot: immediately outputs 0, idx 0; scan restarts from digit 0.
// CONFIGURATION
//  SEG7_DIM_EN defined: CTRL[7:4]=duty D (reset 4'hF). Within a slot, seg_an/seg_out
//   driven only while div_cnt < ((D+1)*SCAN_DIV)>>4, else all 0; D=F = full on.
//   Compare uses integer width >= log2(SCAN_DIV)+5; no overflow.
//  SEG7_DIM_EN undefined: CTRL[7:4] not stored, read 0; full duty always.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=4 unless noted)
//  1 Reset then write DATA=0x0000_1234, run 16 cycles -> seg_an 0001/0010/0100/1000,
//    each held 4 cycles; seg_out 0x66,0x4F,0x5B,0x06 for digits 0..3.
//  2 Write DP=0x5, CTRL=0x201 -> digit0 seg_out=0xE6, digit2 bit7 set, digit1 dark
//    (seg_an=0000, seg_out=0x00 during its slot).
//  3 Write DATA=0xFFFF_ABCD then read addr0, addr1, addr3 -> 0x0000_ABCD,
//    CTRL value, 0x0 each one cycle after the read edge; same-edge write+read returns old.
//  4 Write CTRL=0x0 mid-slot -> seg_an=0 next edge, idx frozen; CTRL=0x1 -> digit 0
//    lit next edge for exactly 4 cycles.
//  5 Pulse rst low mid-slot at digit 2 -> outputs 0 asynchronously, regs at reset
//    values; after release scan restarts at digit 0 showing 0x3F.
//  6 SEG7_DIM_EN, SCAN_DIV=16, CTRL=0x31 -> each digit lit 4 of 16 cycles per slot;
//    without macro CTRL read returns 0x01.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped seven-segment scan controller: DATA / CTRL / DP registers, hex decode, per-digit blanking.
// Optional brightness duty in CTRL[7:4] when SEG7_DIM_EN is defined.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_cs,
    input  logic                  seg_we,
    input  logic [1:0]            seg_addr,
    input  logic [31:0]           seg_wdata,
    output logic [31:0]           seg_rdata,
    output logic [NUM_DIGITS-1:0] seg_an,
    output logic [7:0]            seg_out
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [DW-1:0]         data_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic                  en_q;
`ifdef SEG7_DIM_EN
    logic [3:0]            duty_q;
`endif
    logic [CW-1:0]         div_cnt;
    logic [IW-1:0]         idx;

    logic [31:0]           ctrl_word;
    logic [31:0]           rd_mux;
    logic                  slot_on;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]            seg_next;
    logic                  unused_wdata;

    assign unused_wdata = ^seg_wdata;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        ctrl_word = '0;
        ctrl_word[0] = en_q;
        ctrl_word[8 +: NUM_DIGITS] = blank_q;
`ifdef SEG7_DIM_EN
        ctrl_word[7:4] = duty_q;
`endif
    end

    always_comb begin
        case (seg_addr)
            2'd0:    rd_mux = 32'(data_q);
            2'd1:    rd_mux = ctrl_word;
            2'd2:    rd_mux = 32'(dp_q);
            default: rd_mux = '0;
        endcase
    end

`ifdef SEG7_DIM_EN
    // Five spare bits keep (D+1)*SCAN_DIV exact before the >>4.
    localparam int TW = CW + 5;
    logic [TW-1:0] on_limit;
    always_comb begin
        on_limit = ((TW'(duty_q) + TW'(1)) * TW'(SCAN_DIV)) >> 4;
        slot_on  = TW'(div_cnt) < on_limit;
    end
`else
    assign slot_on = 1'b1;
`endif

    always_comb begin
        an_next  = '0;
        seg_next = '0;
        if (en_q && !blank_q[idx] && slot_on) begin
            an_next[idx] = 1'b1;
            seg_next     = {dp_q[idx], hex7(data_q[{idx, 2'b00} +: 4])};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            dp_q      <= '0;
            blank_q   <= '0;
            en_q      <= 1'b1;
`ifdef SEG7_DIM_EN
            duty_q    <= 4'hF;
`endif
            div_cnt   <= '0;
            idx       <= '0;
            seg_rdata <= '0;
            seg_an    <= '0;
            seg_out   <= '0;
        end else begin
            if (seg_cs && seg_we) begin
                case (seg_addr)
                    2'd0: data_q <= seg_wdata[DW-1:0];
                    2'd1: begin
                        en_q    <= seg_wdata[0];
                        blank_q <= seg_wdata[8 +: NUM_DIGITS];
`ifdef SEG7_DIM_EN
                        duty_q  <= seg_wdata[7:4];
`endif
                    end
                    2'd2: dp_q <= seg_wdata[NUM_DIGITS-1:0];
                    default: ;
                endcase
            end
            if (seg_cs && !seg_we)
                seg_rdata <= rd_mux;

            if (!en_q) begin
                div_cnt <= '0;
                idx     <= '0;
            end else if (div_cnt == CW'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end

            seg_an  <= an_next;
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4) against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam logic [31:0] DATA_MASK = (ND == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * ND)) - 32'h1);
    localparam logic [31:0] DP_MASK   = (32'h1 << ND) - 32'h1;
`ifdef SEG7_DIM_EN
    localparam logic [31:0] CTRL_MASK  = (DP_MASK << 8) | 32'hF1;
    localparam logic [31:0] CTRL_RESET = 32'h0000_00F1;
`else
    localparam logic [31:0] CTRL_MASK  = (DP_MASK << 8) | 32'h01;
    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          seg_cs = 1'b0;
    logic          seg_we = 1'b0;
    logic [1:0]    seg_addr = 2'd0;
    logic [31:0]   seg_wdata = '0;
    logic [31:0]   seg_rdata;
    logic [ND-1:0] seg_an;
    logic [7:0]    seg_out;

    int total = 0;
    int bad = 0;

    // Reference model: register images plus cycles elapsed since the scan (re)started.
    logic [31:0]   m_data, m_dp, m_ctrl;
    int            t;
    logic [ND-1:0] exp_an;
    logic [7:0]    exp_seg;
    logic [31:0]   exp_rd;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .seg_cs(seg_cs), .seg_we(seg_we), .seg_addr(seg_addr),
        .seg_wdata(seg_wdata), .seg_rdata(seg_rdata), .seg_an(seg_an), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexref(input int v);
        case (v)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
            4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
            8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
           12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic model_reset();
        m_data = '0; m_dp = '0; m_ctrl = CTRL_RESET; t = 0;
        exp_an = '0; exp_seg = '0; exp_rd = '0;
    endtask

    task automatic step();
        int digit, phase, duty, limit;
        logic lit;
        @(posedge clk);
        digit = (t / SD) % ND;
        phase = t % SD;
`ifdef SEG7_DIM_EN
        duty = int'(m_ctrl[7:4]);
`else
        duty = 15;
`endif
        limit = ((duty + 1) * SD) / 16;
        lit = m_ctrl[0] && !m_ctrl[8 + digit] && (phase < limit);
        exp_an = '0;
        exp_seg = '0;
        if (lit) begin
            exp_an[digit] = 1'b1;
            exp_seg = {m_dp[digit], hexref(int'((m_data >> (4 * digit)) & 32'hF))};
        end
        if (m_ctrl[0]) t++; else t = 0;
        if (seg_cs && !seg_we) begin
            case (seg_addr)
                2'd0: exp_rd = m_data;
                2'd1: exp_rd = m_ctrl;
                2'd2: exp_rd = m_dp;
                default: exp_rd = '0;
            endcase
        end
        if (seg_cs && seg_we) begin
            case (seg_addr)
                2'd0: m_data = seg_wdata & DATA_MASK;
                2'd1: m_ctrl = seg_wdata & CTRL_MASK;
                2'd2: m_dp   = seg_wdata & DP_MASK;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic bus(input logic cs, input logic we, input logic [1:0] a, input logic [31:0] d);
        seg_cs = cs; seg_we = we; seg_addr = a; seg_wdata = d;
        step();
        seg_cs = 1'b0; seg_we = 1'b0; seg_addr = 2'd0; seg_wdata = '0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (seg_an !== '0 || seg_out !== 8'h00 || seg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state an=%b seg=%h rd=%h, want 0/00/0", seg_an, seg_out, seg_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        total++;
        if (seg_an !== 4'b0001 || seg_out !== 8'h3F) begin
            bad++;
            $display("FAIL reset_first_digit an=%b seg=%h, want 0001/3f", seg_an, seg_out);
        end
        bus(1'b1, 1'b0, 2'd1, '0);
        total++;
        if (seg_rdata !== exp_rd) begin
            bad++;
            $display("FAIL reset_ctrl_read rd=%h, want %h", seg_rdata, exp_rd);
        end
    endtask

    task automatic test_scan();
        bus(1'b1, 1'b1, 2'd0, 32'h0000_1234);
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (seg_an !== exp_an || seg_out !== exp_seg) begin
                bad++;
                $display("FAIL scan[%0d] an=%b seg=%h, want an=%b seg=%h", i, seg_an, seg_out, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_dp_blank();
        bus(1'b1, 1'b1, 2'd2, 32'h0000_0005);
        bus(1'b1, 1'b1, 2'd1, 32'h0000_0201);
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (seg_an !== exp_an || seg_out !== exp_seg) begin
                bad++;
                $display("FAIL dp_blank[%0d] an=%b seg=%h, want an=%b seg=%h", i, seg_an, seg_out, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_regs();
        bus(1'b1, 1'b1, 2'd0, 32'hFFFF_ABCD);
        bus(1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF);
        for (int a = 0; a < 4; a++) begin
            bus(1'b1, 1'b0, 2'(a), 32'hFFFF_FFFF);
            total++;
            if (seg_rdata !== exp_rd) begin
                bad++;
                $display("FAIL reg_read[%0d] rd=%h, want %h", a, seg_rdata, exp_rd);
            end
        end
        bus(1'b1, 1'b0, 2'd0, '0);
        total++;
        if (seg_rdata !== 32'h0000_ABCD) begin
            bad++;
            $display("FAIL data_read rd=%h, want 0000abcd", seg_rdata);
        end
        repeat (3) step();
        total++;
        if (seg_rdata !== exp_rd) begin
            bad++;
            $display("FAIL read_hold rd=%h, want %h", seg_rdata, exp_rd);
        end
        bus(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFA);
        bus(1'b1, 1'b0, 2'd2, '0);
        total++;
        if (seg_rdata !== exp_rd) begin
            bad++;
            $display("FAIL dp_masked_read rd=%h, want %h", seg_rdata, exp_rd);
        end
    endtask

    task automatic test_enable();
        int guard = 0;
        bus(1'b1, 1'b1, 2'd1, 32'h0000_0001);
        while (t % SD != 2 && guard < 64) begin
            step();
            guard++;
        end
        bus(1'b1, 1'b1, 2'd1, 32'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (seg_an !== exp_an || seg_out !== exp_seg) begin
                bad++;
                $display("FAIL disabled[%0d] an=%b seg=%h, want an=%b seg=%h", i, seg_an, seg_out, exp_an, exp_seg);
            end
        end
        bus(1'b1, 1'b1, 2'd1, 32'h0000_0001);
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (seg_an !== exp_an || seg_out !== exp_seg) begin
                bad++;
                $display("FAIL reenable[%0d] an=%b seg=%h, want an=%b seg=%h", i, seg_an, seg_out, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!((t / SD) % ND == 2 && t % SD == 2) && guard < 64) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 64) begin
            bad++;
            $display("FAIL reset_mid_sync reached=%0d, want digit 2 mid-slot", guard);
        end
        rst = 1'b0;
        #2;
        model_reset();
        total++;
        if (seg_an !== '0 || seg_out !== 8'h00 || seg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_async an=%b seg=%h rd=%h, want 0/00/0", seg_an, seg_out, seg_rdata);
        end
        rst = 1'b1;
        step();
        total++;
        if (seg_an !== 4'b0001 || seg_out !== 8'h3F) begin
            bad++;
            $display("FAIL reset_mid_restart an=%b seg=%h, want 0001/3f", seg_an, seg_out);
        end
        bus(1'b1, 1'b0, 2'd1, '0);
        total++;
        if (seg_rdata !== CTRL_RESET) begin
            bad++;
            $display("FAIL reset_mid_ctrl rd=%h, want %h", seg_rdata, CTRL_RESET);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [1:0]  a;
        logic        cs, we;
        for (int i = 0; i < 400; i++) begin
            cs = ($urandom % 3) == 0;
            we = $urandom % 2;
            a  = 2'($urandom % 4);
            d  = $urandom;
            if (a == 2'd1 && we) d[0] = ($urandom % 4) != 0;
            bus(cs, we, a, d);
            total++;
            if (seg_an !== exp_an || seg_out !== exp_seg || seg_rdata !== exp_rd) begin
                bad++;
                $display("FAIL random[%0d] an=%b seg=%h rd=%h, want an=%b seg=%h rd=%h",
                         i, seg_an, seg_out, seg_rdata, exp_an, exp_seg, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dp_blank();
        test_regs();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
